// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between NREQ valid/ready requesters
module alu_arbiter #(
  parameter int NREQ = 2,
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_ain,
  input  logic [NREQ*W-1:0] req_bin,
  input  logic [NREQ*3-1:0] req_op,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic [2:0]        rsp_status,
  output logic [W-1:0]      alu_ain,
  output logic [W-1:0]      alu_bin,
  output logic [2:0]        alu_op,
  input  logic [W-1:0]      alu_out,
  input  logic [2:0]        alu_status,
  output logic              busy
);
  localparam int PW = $clog2(NREQ);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [PW-1:0] ptr, gnt_id, g;
  logic [W-1:0] a_q, b_q;
  logic [2:0] op_q;
  logic any_v, accept_ok, accept, found;
  always_comb begin
    g = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
        g = PW'((int'(ptr) + k) % NREQ);
        found = 1'b1;
      end
    end
  end
  assign any_v = |req_valid;
  // rsp_valid[gnt_id] is always set in RESP, so the handshake alone frees the ALU
  assign accept_ok = (state == IDLE) | (state == RESP & rsp_valid[gnt_id] & rsp_ready[gnt_id]);
  assign accept = accept_ok & any_v;
  assign req_ready = accept ? NREQ'(1) << g : '0;
  assign alu_ain = a_q;
  assign alu_bin = b_q;
  assign alu_op = op_q;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      gnt_id <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      rsp_data <= '0;
      rsp_status <= '0;
      rsp_valid <= '0;
    end else begin
      if (accept) begin
        a_q <= req_ain[int'(g)*W +: W];
        b_q <= req_bin[int'(g)*W +: W];
        op_q <= req_op[int'(g)*3 +: 3];
        gnt_id <= g;
        ptr <= (g == PW'(NREQ-1)) ? '0 : g + 1'b1;
      end
      state <= accept ? EXEC : (state == EXEC) ? RESP :
               (state == RESP && rsp_ready[gnt_id]) ? IDLE : state;
      if (state == EXEC) begin
        rsp_data <= alu_out;
        rsp_status <= alu_status;
        rsp_valid <= NREQ'(1) << gnt_id;
      end else if (state == RESP && rsp_ready[gnt_id]) begin
        rsp_valid <= '0;
      end
    end
  end
endmodule
